// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : display_pkg                                                |
// | Brief   : Shared constants for the multiplexed display scan logic.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package display_pkg;

    localparam int NIB_W = 4;

    localparam logic [0:0] S_GUARD = 1'b0;
    localparam logic [0:0] S_SHOW  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : scan_timer                                                  |
// | Brief  : Loadable down-counter with terminal-count output.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module scan_timer #(
    parameter int WIDTH = 16,
    parameter int INIT  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= INIT_V;
        end else if (load) begin
            count <= load_value;
        end else begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : display_scan_ctrl                                           |
// | Brief  : Guarded multi-digit scan with frame-coherent value loading. |
// |          Option DISPLAY_SCAN_ZERO_BLANK_EN blanks leading zeros.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      load_valid,
    input  logic [NIB_W*DIGITS-1:0]   load_value,
    output logic                      load_ready,
    output logic [DIGITS-1:0]         digit_sel,
    output logic [NIB_W-1:0]          nibble_out,
    output logic                      frame_tick
);

    localparam int MAXC = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] GUARD_RLD = CW'(GUARD - 1);
    localparam logic [CW-1:0] DIV_RLD   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [0:0]              state, state_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [NIB_W*DIGITS-1:0] active, pending, active_nxt;
    logic [CW-1:0]           reload;
    logic                    tc, frame_end;
    logic [DIGITS-1:0]       blank, sel_nxt;
    logic [NIB_W-1:0]        nib_nxt;

    scan_timer #(
        .WIDTH (CW),
        .INIT  (GUARD - 1)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tc),
        .load_value (reload),
        .tc         (tc)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        reload    = GUARD_RLD;
        if (tc) begin
            if (state == S_GUARD) begin
                state_nxt = S_SHOW;
                reload    = DIV_RLD;
            end else begin
                state_nxt = S_GUARD;
                idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    assign frame_end  = tc && (state == S_SHOW) && (idx == IDX_LAST);
    assign active_nxt = frame_end ? pending : active;

`ifdef DISPLAY_SCAN_ZERO_BLANK_EN
    // A digit is blank when it and every more significant nibble are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_blank
        if (i == 0) begin : g_lsd
            assign blank[i] = 1'b0;
        end else begin : g_upper
            assign blank[i] = (active_nxt[NIB_W*DIGITS-1:NIB_W*i] == '0);
        end
    end
`else
    assign blank = '0;
`endif

    // Outputs are computed from next-state values so the registered pins line up with the FSM.
    always_comb begin
        nib_nxt = '0;
        sel_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nib_nxt = active_nxt[NIB_W*i +: NIB_W];
            end
            sel_nxt[i] = !((state_nxt == S_SHOW) && (idx_nxt == IW'(i)) && !blank[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_GUARD;
            idx        <= '0;
            digit_sel  <= '1;
            nibble_out <= '0;
            active     <= '0;
            pending    <= '0;
            load_ready <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            digit_sel  <= sel_nxt;
            nibble_out <= nib_nxt;
            active     <= active_nxt;
            frame_tick <= frame_end;
            if (load_valid && load_ready) begin
                pending    <= load_value;
                load_ready <= 1'b0;
            end else if (frame_end) begin
                load_ready <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
